// File: rtl/mac_sched_pkg.sv
// rtl/mac_sched_pkg.sv - shared types and width helpers for mac_tree_scheduler
package mac_sched_pkg;

    localparam int TAG_ID_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    function automatic int calc_res_w(input int data_w, input int coeff_w);
        return data_w + coeff_w + 2;
    endfunction

    function automatic int calc_id_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/mac_sched_rr_arbiter.sv
// rtl/mac_sched_rr_arbiter.sv - one-hot round-robin grant starting the search at ptr
module mac_sched_rr_arbiter
    import mac_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int ID_W = calc_id_w(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        logic            found;
        logic [ID_W:0]   sum;
        logic [ID_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            idx = sum[ID_W-1:0];
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mac_tree_scheduler.sv
// rtl/mac_tree_scheduler.sv - round-robin issue to a shared multiply-add tree with in-order result FIFO
// Optional feature macro: MAC_SCHED_STATS_EN (per-requester grant and stall counters).
module mac_tree_scheduler
    import mac_sched_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int PIPE_LAT    = 2,
    parameter int FIFO_DEPTH  = 8,
    localparam int RES_W = calc_res_w(DATA_WIDTH, COEFF_WIDTH),
    localparam int ID_W  = calc_id_w(NUM_REQ)
)(
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data2,
    input  logic [NUM_REQ*COEFF_WIDTH-1:0] req_coeff1,
    input  logic [NUM_REQ*COEFF_WIDTH-1:0] req_coeff2,
    output logic                           tree_valid,
    output logic [DATA_WIDTH-1:0]          tree_data1,
    output logic [DATA_WIDTH-1:0]          tree_data2,
    output logic [COEFF_WIDTH-1:0]         tree_coeff1,
    output logic [COEFF_WIDTH-1:0]         tree_coeff2,
    input  logic [RES_W-1:0]               tree_result,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic [RES_W-1:0]               res_data,
    output logic [ID_W-1:0]                res_id,
    input  logic                           drain,
    output logic                           drain_done,
    output logic                           busy
`ifdef MAC_SCHED_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]          stat_grants,
    output logic [31:0]                    stat_stall
`endif
);

    localparam int FIFO_AW = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    sched_state_e             state_q, state_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic                     drain_armed_q, drain_armed_d;
    logic                     tree_valid_q, tree_valid_d;
    logic [ID_W-1:0]          tree_id_q, tree_id_d;
    logic [DATA_WIDTH-1:0]    tree_data1_q, tree_data1_d, tree_data2_q, tree_data2_d;
    logic [COEFF_WIDTH-1:0]   tree_coeff1_q, tree_coeff1_d, tree_coeff2_q, tree_coeff2_d;
    tag_t                     tag_q [PIPE_LAT];
    tag_t                     tag_d [PIPE_LAT];
    logic [RES_W-1:0]         fifo_data_q [FIFO_DEPTH];
    logic [ID_W-1:0]          fifo_id_q [FIFO_DEPTH];
    logic [FIFO_AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]         count_q, count_d, inflight_q, inflight_d;

    logic [CNT_W:0]           occupancy;
    logic                     grant_en, transfer, push, pop, pipe_empty;
    logic [NUM_REQ-1:0]       grant;
    logic [ID_W-1:0]          gnt_idx;
    tag_t                     cap_tag;
    logic                     unused_tag_id;

    // Credit counts issued-but-uncaptured work so a capture can never overflow the FIFO.
    assign occupancy  = {1'b0, inflight_q} + {1'b0, count_q};
    assign grant_en   = !reset && !drain && (state_q != DRAIN)
                        && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    assign transfer   = |grant;
    assign cap_tag    = tag_q[PIPE_LAT-1];
    assign push       = cap_tag.valid;
    assign pop        = res_valid && res_ready;
    assign pipe_empty = (inflight_q == '0) && (count_q == '0);
    assign unused_tag_id = ^cap_tag.id;

    mac_sched_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .enable (grant_en),
        .grant  (grant)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) gnt_idx = ID_W'(i);
        end

        ptr_d         = ptr_q;
        tree_valid_d  = transfer;
        tree_id_d     = tree_id_q;
        tree_data1_d  = tree_data1_q;
        tree_data2_d  = tree_data2_q;
        tree_coeff1_d = tree_coeff1_q;
        tree_coeff2_d = tree_coeff2_q;
        if (transfer) begin
            ptr_d         = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            tree_id_d     = gnt_idx;
            tree_data1_d  = req_data1[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            tree_data2_d  = req_data2[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
            tree_coeff1_d = req_coeff1[int'(gnt_idx)*COEFF_WIDTH +: COEFF_WIDTH];
            tree_coeff2_d = req_coeff2[int'(gnt_idx)*COEFF_WIDTH +: COEFF_WIDTH];
        end

        tag_d[0].valid = tree_valid_q;
        tag_d[0].id    = TAG_ID_W'(tree_id_q);
        for (int i = 1; i < PIPE_LAT; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == FIFO_AW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == FIFO_AW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        inflight_d = inflight_q + CNT_W'(transfer) - CNT_W'(push);

        state_d = state_q;
        case (state_q)
            IDLE:  if (drain && drain_armed_q) state_d = DRAIN;
                   else if (transfer)          state_d = RUN;
            RUN:   if (drain)                  state_d = DRAIN;
                   else if (pipe_empty && !transfer) state_d = IDLE;
            DRAIN: if (pipe_empty)             state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
        // A held drain completes once; it must drop before another drain_done can fire.
        drain_armed_d = !drain ? 1'b1 : (drain_done ? 1'b0 : drain_armed_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            drain_armed_q <= 1'b1;
            tree_valid_q  <= 1'b0;
            tree_id_q     <= '0;
            tree_data1_q  <= '0;
            tree_data2_q  <= '0;
            tree_coeff1_q <= '0;
            tree_coeff2_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) tag_q[i] <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            inflight_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            drain_armed_q <= drain_armed_d;
            tree_valid_q  <= tree_valid_d;
            tree_id_q     <= tree_id_d;
            tree_data1_q  <= tree_data1_d;
            tree_data2_q  <= tree_data2_d;
            tree_coeff1_q <= tree_coeff1_d;
            tree_coeff2_q <= tree_coeff2_d;
            tag_q         <= tag_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            if (push) begin
                fifo_data_q[wr_ptr_q] <= tree_result;
                fifo_id_q[wr_ptr_q]   <= cap_tag.id[ID_W-1:0];
            end
        end
    end

    assign req_ready   = grant;
    assign tree_valid  = tree_valid_q;
    assign tree_data1  = tree_data1_q;
    assign tree_data2  = tree_data2_q;
    assign tree_coeff1 = tree_coeff1_q;
    assign tree_coeff2 = tree_coeff2_q;
    assign res_valid   = (count_q != '0);
    assign res_data    = res_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign res_id      = res_valid ? fifo_id_q[rd_ptr_q] : '0;
    assign drain_done  = (state_q == DRAIN) && pipe_empty;
    assign busy        = (state_q != IDLE) || (inflight_q != '0) || (count_q != '0);

`ifdef MAC_SCHED_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];
    logic [31:0] grant_cnt_d [NUM_REQ];
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt_d[i] = grant_cnt_q[i];
            if (grant[i] && grant_cnt_q[i] != '1) grant_cnt_d[i] = grant_cnt_q[i] + 32'd1;
        end
        stall_cnt_d = stall_cnt_q;
        if (|req_valid && !transfer && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        stat_grants = '0;
        for (int i = 0; i < NUM_REQ; i++) stat_grants[i*32 +: 32] = grant_cnt_q[i];
    end
    assign stat_stall = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_tree_scheduler.sv
// tb/tb_mac_tree_scheduler.sv - scoreboard bench for mac_tree_scheduler with a 2-cycle tree model
module tb_mac_tree_scheduler;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int RW = DW + CW + 2;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_data1, req_data2;
    logic [NR*CW-1:0]  req_coeff1, req_coeff2;
    logic              tree_valid;
    logic [DW-1:0]     tree_data1, tree_data2;
    logic [CW-1:0]     tree_coeff1, tree_coeff2;
    logic [RW-1:0]     tree_result;
    logic              res_valid, res_ready;
    logic [RW-1:0]     res_data;
    logic [IW-1:0]     res_id;
    logic              drain, drain_done, busy;
`ifdef MAC_SCHED_STATS_EN
    logic [NR*32-1:0]  stat_grants;
    logic [31:0]       stat_stall;
`endif

    mac_tree_scheduler dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data1(req_data1), .req_data2(req_data2),
        .req_coeff1(req_coeff1), .req_coeff2(req_coeff2),
        .tree_valid(tree_valid), .tree_data1(tree_data1), .tree_data2(tree_data2),
        .tree_coeff1(tree_coeff1), .tree_coeff2(tree_coeff2), .tree_result(tree_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .drain(drain), .drain_done(drain_done), .busy(busy)
`ifdef MAC_SCHED_STATS_EN
        , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    always #5 clk = ~clk;

    // Tree model: d1*c1 + d2*c2, two cycles after the operands are presented.
    logic [RW-1:0] tr_s1;
    always @(posedge clk) begin
        tr_s1       <= RW'(int'(tree_data1) * int'(tree_coeff1) + int'(tree_data2) * int'(tree_coeff2));
        tree_result <= tr_s1;
    end

    int checks = 0;
    int errors = 0;
    int grants = 0;
    int pops = 0;
    int dd_pulses = 0;
    logic [IW+RW-1:0] exp_q[$];
    int grant_log[$];
    logic [IW+RW-1:0] exp_item;

    function automatic logic [RW-1:0] model_res(input int i);
        int d1, d2, c1, c2;
        d1 = int'(req_data1[i*DW +: DW]);
        d2 = int'(req_data2[i*DW +: DW]);
        c1 = int'(req_coeff1[i*CW +: CW]);
        c2 = int'(req_coeff2[i*CW +: CW]);
        return RW'(d1 * c1 + d2 * c2);
    endfunction

    // Scoreboard: push on every observed transfer, pop and compare on every accepted result.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({IW'(i), model_res(i)});
                    grant_log.push_back(i);
                    grants++;
                end
            end
            if (drain_done) dd_pulses++;
            if (res_valid && res_ready) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: got id=%0d data=%0d, required no result", res_id, res_data);
                end else begin
                    exp_item = exp_q.pop_front();
                    if ({res_id, res_data} !== exp_item) begin
                        errors++;
                        $display("FAIL sb_result: got id=%0d data=%0d, required id=%0d data=%0d",
                                 res_id, res_data, exp_item[RW +: IW], exp_item[RW-1:0]);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ops();
        req_data1  = (NR*DW)'($urandom);
        req_data2  = (NR*DW)'($urandom);
        req_coeff1 = (NR*CW)'($urandom);
        req_coeff2 = (NR*CW)'($urandom);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        drain     = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        grant_log.delete();
        grants = 0;
        pops = 0;
        dd_pulses = 0;
    endtask

    task automatic wait_empty(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid && !busy) begin
                ok = 1'b1;
                break;
            end
            next_cycle();
        end
        if (ok) next_cycle();
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        req_valid = '1;
        drain     = 1'b0;
        res_ready = 1'b1;
        randomize_ops();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (req_ready !== '0) begin
            errors++; $display("FAIL reset_req_ready: got %b, required 0", req_ready);
        end
        checks++;
        if ({tree_valid, tree_data1, tree_data2, tree_coeff1, tree_coeff2} !== '0) begin
            errors++; $display("FAIL reset_tree: got valid=%b d1=%0d d2=%0d c1=%0d c2=%0d, required all 0",
                               tree_valid, tree_data1, tree_data2, tree_coeff1, tree_coeff2);
        end
        checks++;
        if ({res_valid, res_data, res_id} !== '0) begin
            errors++; $display("FAIL reset_res: got valid=%b data=%0d id=%0d, required all 0", res_valid, res_data, res_id);
        end
        checks++;
        if ({drain_done, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_status: got drain_done=%b busy=%b, required 0 0", drain_done, busy);
        end
        apply_reset();
    endtask

    task automatic test_single_req();
        int lat;
        bit ok;
        apply_reset();
        req_data1[2*DW +: DW]  = 8'd3;
        req_data2[2*DW +: DW]  = 8'd4;
        req_coeff1[2*CW +: CW] = 8'd5;
        req_coeff2[2*CW +: CW] = 8'd6;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_grant: got %b, required 0100", req_ready);
        end
        next_cycle();
        req_valid = '0;
        lat = 0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = n;
                break;
            end
            next_cycle();
        end
        checks++;
        if (lat != 4) begin
            errors++; $display("FAIL single_latency: got %0d cycles, required 4", lat);
        end
        checks++;
        if (res_data !== RW'(39) || res_id !== IW'(2)) begin
            errors++; $display("FAIL single_result: got data=%0d id=%0d, required data=39 id=2", res_data, res_id);
        end
        next_cycle();
        wait_empty(20, ok);
        checks++;
        if (!ok || pops != 1) begin
            errors++; $display("FAIL single_drain: got ok=%0d pops=%0d, required ok=1 pops=1", ok, pops);
        end
    endtask

    task automatic test_round_robin();
        int onehot_bad;
        bit ok;
        apply_reset();
        req_valid  = '1;
        onehot_bad = 0;
        for (int c = 0; c < 12; c++) begin
            randomize_ops();
            @(negedge clk);
            if (!$onehot(req_ready)) onehot_bad++;
            next_cycle();
        end
        req_valid = '0;
        checks++;
        if (onehot_bad != 0) begin
            errors++; $display("FAIL rr_one_per_cycle: got %0d cycles without a single grant, required 0", onehot_bad);
        end
        checks++;
        if (grants != 12) begin
            errors++; $display("FAIL rr_grant_count: got %0d, required 12", grants);
        end
        for (int k = 0; k < 12 && k < grant_log.size(); k++) begin
            checks++;
            if (grant_log[k] != k % NR) begin
                errors++; $display("FAIL rr_order[%0d]: got %0d, required %0d", k, grant_log[k], k % NR);
            end
        end
        wait_empty(40, ok);
        checks++;
        if (!ok || pops != 12) begin
            errors++; $display("FAIL rr_drain: got ok=%0d pops=%0d, required ok=1 pops=12", ok, pops);
        end
    endtask

    task automatic test_back_pressure();
        logic          held;
        logic [RW-1:0] hold_data;
        logic [IW-1:0] hold_id;
        bit ok;
        apply_reset();
        res_ready = 1'b0;
        req_valid = '1;
        held      = 1'b0;
        hold_data = '0;
        hold_id   = '0;
        for (int c = 0; c < 20; c++) begin
            randomize_ops();
            @(negedge clk);
            if (res_valid && !held) begin
                held      = 1'b1;
                hold_data = res_data;
                hold_id   = res_id;
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (grants != 8) begin
            errors++; $display("FAIL bp_credit_grants: got %0d, required 8", grants);
        end
        checks++;
        if (req_ready !== '0 || res_valid !== 1'b1) begin
            errors++; $display("FAIL bp_stalled: got req_ready=%b res_valid=%b, required 0000 1", req_ready, res_valid);
        end
        checks++;
        if (!held || res_data !== hold_data || res_id !== hold_id) begin
            errors++; $display("FAIL bp_hold: got data=%0d id=%0d, required data=%0d id=%0d", res_data, res_id, hold_data, hold_id);
        end
        next_cycle();
        res_ready = 1'b1;
        for (int c = 0; c < 30 && pops < 10; c++) begin
            randomize_ops();
            next_cycle();
        end
        checks++;
        if (grants <= 8) begin
            errors++; $display("FAIL bp_resume: got %0d grants, required more than 8", grants);
        end
        req_valid = '0;
        wait_empty(60, ok);
        checks++;
        if (!ok || pops != grants) begin
            errors++; $display("FAIL bp_drain: got ok=%0d pops=%0d, required ok=1 pops=%0d", ok, pops, grants);
        end
    endtask

    task automatic test_drain();
        int blocked_bad;
        apply_reset();
        req_valid = '1;
        randomize_ops();
        repeat (3) next_cycle();
        drain       = 1'b1;
        blocked_bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (req_ready !== '0) blocked_bad++;
            next_cycle();
        end
        checks++;
        if (blocked_bad != 0 || grants != 3) begin
            errors++; $display("FAIL drain_blocked: got %0d granting cycles and %0d grants, required 0 and 3", blocked_bad, grants);
        end
        checks++;
        if (pops != 3 || exp_q.size() != 0) begin
            errors++; $display("FAIL drain_results: got pops=%0d left=%0d, required 3 and 0", pops, exp_q.size());
        end
        checks++;
        if (dd_pulses != 1) begin
            errors++; $display("FAIL drain_done_count: got %0d, required 1", dd_pulses);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL drain_busy: got %b, required 0", busy);
        end
        next_cycle();
        req_valid = '0;
        drain     = 1'b0;
        next_cycle();
        drain = 1'b1;
        @(negedge clk);
        checks++;
        if (drain_done !== 1'b0) begin
            errors++; $display("FAIL idle_drain_t0: got %b, required 0", drain_done);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (drain_done !== 1'b1) begin
            errors++; $display("FAIL idle_drain_t1: got %b, required 1", drain_done);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (drain_done !== 1'b0) begin
            errors++; $display("FAIL idle_drain_t2: got %b, required 0", drain_done);
        end
        next_cycle();
        drain = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        int stale;
        apply_reset();
        req_valid = '1;
        randomize_ops();
        repeat (2) next_cycle();
        req_valid = '0;
        reset     = 1'b1;
        next_cycle();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if ({res_valid, tree_valid, busy, req_ready} !== '0 || tree_data1 !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got res_valid=%b tree_valid=%b busy=%b req_ready=%b d1=%0d, required all 0",
                               res_valid, tree_valid, busy, req_ready, tree_data1);
        end
        next_cycle();
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (res_valid || busy) stale++;
            next_cycle();
        end
        checks++;
        if (stale != 0 || pops != 0) begin
            errors++; $display("FAIL mid_reset_stale: got %0d stale cycles pops=%0d, required 0 and 0", stale, pops);
        end
    endtask

`ifdef MAC_SCHED_STATS_EN
    task automatic test_stats();
        bit ok;
        apply_reset();
        @(negedge clk);
        checks++;
        if (stat_grants !== '0 || stat_stall !== '0) begin
            errors++; $display("FAIL stats_reset: got grants=%h stall=%0d, required 0 0", stat_grants, stat_stall);
        end
        next_cycle();
        drain     = 1'b1;
        req_valid = 4'b0010;
        repeat (5) next_cycle();
        drain     = 1'b0;
        req_valid = '0;
        next_cycle();
        req_valid = 4'b0010;
        randomize_ops();
        repeat (10) next_cycle();
        req_valid = '0;
        wait_empty(30, ok);
        @(negedge clk);
        checks++;
        if (stat_grants[32 +: 32] !== 32'd10) begin
            errors++; $display("FAIL stats_grants1: got %0d, required 10", stat_grants[32 +: 32]);
        end
        checks++;
        if ({stat_grants[127:64], stat_grants[31:0]} !== '0) begin
            errors++; $display("FAIL stats_grants_other: got %h, required 0", stat_grants);
        end
        checks++;
        if (stat_stall !== 32'd5) begin
            errors++; $display("FAIL stats_stall: got %0d, required 5", stat_stall);
        end
        next_cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_data1  = '0;
        req_data2  = '0;
        req_coeff1 = '0;
        req_coeff2 = '0;
        drain      = 1'b0;
        res_ready  = 1'b1;
        test_reset();
        test_single_req();
        test_round_robin();
        test_back_pressure();
        test_drain();
        test_reset_mid();
`ifdef MAC_SCHED_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
